fxp_div_iter: RTL

- Parametrised, handshaked, iterative fixed-point divider; next generation of the fixed three-cycle shift-add divider used in the QR datapath (normalisation of column elements by the diagonal).
- Computes q = a / b on W-bit words sharing FRAC fractional bits, with exact radix-2 restoring division instead of approximation.
- Adds signed/unsigned divisor mode, selectable rounding, saturation and divide-by-zero/overflow flags.
- Uses valid/ready on both sides so it can sit between the R-matrix buffer and the Q-update pipeline with back-pressure.

---
 rtl/fxp_div_iter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/fxp_div_iter.sv
// fxp_div_iter -- iterative radix-2 restoring fixed-point divider.
//
// Computes q = a / b on W-bit words that share FRAC fractional bits. One
// quotient bit is produced per cycle (W+FRAC iterations), followed by a
// fix-up cycle that applies rounding, saturation and divide-by-zero handling.
// Operands and results use valid/ready handshakes, so the block tolerates
// back-pressure from the consumer.
//
// Parameters:
//   W        word width of a, b and q (a and q are two's complement)
//   FRAC     fractional bits of a, b and q (0 <= FRAC < W)
//   B_SIGNED 0: b is an unsigned magnitude, 1: b is two's complement
//   ROUND    0: truncate toward zero, 1: round half away from zero
//
// Ports:
//   i_clk    clock, all state on the rising edge
//   i_rst_n  asynchronous active-low reset
//   i_valid  operand valid          o_ready  divider can accept operands
//   i_a      dividend (signed)      i_b      divisor (signedness per B_SIGNED)
//   o_valid  result valid           i_ready  consumer accepts result
//   o_q      quotient, signed, FRAC fractional bits
//   o_ovf    quotient saturated     o_dz     divide by zero
module fxp_div_iter #(
  parameter int W        = 16,
  parameter int FRAC     = 14,
  parameter int B_SIGNED = 0,
  parameter int ROUND    = 0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_q,
  output logic         o_ovf,
  output logic         o_dz
);

  localparam int N  = W + FRAC;
  localparam int CW = $clog2(N + 1);

  localparam logic [N:0]   LIM_POS = ((N+1)'(1) << (W - 1)) - (N+1)'(1);
  localparam logic [N:0]   LIM_NEG = (N+1)'(1) << (W - 1);
  localparam logic [W-1:0] Q_MAX   = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] Q_MIN   = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [N-1:0]  dvd_q;     // shifted dividend; quotient bits enter at the LSB
  logic [W-1:0]  rem_q;     // partial remainder, always < divisor
  logic [W-1:0]  dvs_q;     // divisor magnitude
  logic          sign_q;    // sign of the quotient
  logic          a_neg_q;   // sign of the dividend, selects the dz result
  logic          o_ready_q;
  logic          o_valid_q;
  logic [W-1:0]  o_q_q;
  logic          o_ovf_q;
  logic          o_dz_q;

  // Operand conditioning. The most-negative value maps to 2^(W-1) as an
  // unsigned magnitude, so no wrap occurs.
  logic         a_neg_d;
  logic         b_neg_d;
  logic [W-1:0] a_mag_d;
  logic [W-1:0] b_mag_d;

  // One restoring step.
  logic [W:0]   rem_sh_d;
  logic         qbit_d;
  logic [W-1:0] rem_d;

  // Fix-up of the finished quotient.
  logic         round_inc_d;
  logic [N:0]   m_d;
  logic         over_d;
  logic [W-1:0] q_d;

  always_comb begin
    a_neg_d = i_a[W-1];
    b_neg_d = (B_SIGNED != 0) ? i_b[W-1] : 1'b0;
    a_mag_d = a_neg_d ? (~i_a + 1'b1) : i_a;
    b_mag_d = b_neg_d ? (~i_b + 1'b1) : i_b;

    rem_sh_d = {rem_q, dvd_q[N-1]};
    qbit_d   = (rem_sh_d >= {1'b0, dvs_q});
    rem_d    = qbit_d ? W'(rem_sh_d - {1'b0, dvs_q}) : rem_sh_d[W-1:0];

    // 2*rem >= |b| is the "fraction >= 1/2" test for half-away rounding.
    round_inc_d = (ROUND != 0) && ({rem_q, 1'b0} >= {1'b0, dvs_q});
    m_d         = {1'b0, dvd_q} + (N+1)'(round_inc_d);
    over_d      = m_d > (sign_q ? LIM_NEG : LIM_POS);

    if (dvs_q == '0) begin
      q_d = a_neg_q ? Q_MIN : Q_MAX;
    end else if (over_d) begin
      q_d = sign_q ? Q_MIN : Q_MAX;
    end else begin
      q_d = sign_q ? (~m_d[W-1:0] + 1'b1) : m_d[W-1:0];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dvd_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      sign_q    <= 1'b0;
      a_neg_q   <= 1'b0;
      o_ready_q <= 1'b1;
      o_valid_q <= 1'b0;
      o_q_q     <= '0;
      o_ovf_q   <= 1'b0;
      o_dz_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_valid && o_ready_q) begin
            sign_q    <= a_neg_d ^ b_neg_d;
            a_neg_q   <= a_neg_d;
            dvd_q     <= N'(a_mag_d) << FRAC;
            dvs_q     <= b_mag_d;
            rem_q     <= '0;
            cnt_q     <= '0;
            o_ready_q <= 1'b0;
            o_ovf_q   <= 1'b0;
            o_dz_q    <= 1'b0;
            state_q   <= CALC;
          end
        end
        CALC: begin
          rem_q <= rem_d;
          dvd_q <= {dvd_q[N-2:0], qbit_d};
          if (cnt_q == CW'(N - 1)) begin
            state_q <= FIX;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        FIX: begin
          o_q_q   <= q_d;
          o_dz_q  <= (dvs_q == '0);
          o_ovf_q <= (dvs_q != '0) && over_d;
          state_q <= DONE;
        end
        DONE: begin
          // Result registers settle on DONE entry; o_valid follows one
          // cycle later so the full latency is N+2 edges.
          if (!o_valid_q) begin
            o_valid_q <= 1'b1;
          end else if (i_ready) begin
            o_valid_q <= 1'b0;
            o_ready_q <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_ready = o_ready_q;
  assign o_valid = o_valid_q;
  assign o_q     = o_q_q;
  assign o_ovf   = o_ovf_q;
  assign o_dz    = o_dz_q;

endmodule
